// File: rtl/lcd_pixel_tx.sv
// lcd_pixel_tx: parallel RGB panel transmitter (pixel divider, H/V timing, stream sync, underflow count).
// Defining LCD_TESTPAT_EN adds the tpat_sel input and an 8-bar colour test pattern.
//   state | meaning
//   SEEK  | discarding stream until a sof pixel can be taken at (0,0)
//   LOCK  | one pixel taken per active-area tick
module lcd_pixel_tx #(
    parameter int          CLK_DIV  = 2,
    parameter int          H_ACTIVE = 800,
    parameter int          H_FP     = 40,
    parameter int          H_SYNC   = 128,
    parameter int          H_BP     = 88,
    parameter int          V_ACTIVE = 480,
    parameter int          V_FP     = 1,
    parameter int          V_SYNC   = 3,
    parameter int          V_BP     = 21,
    parameter logic [23:0] UF_COLOR = 24'hFF00FF
) (
    input  logic        clk,
    input  logic        rst,
`ifdef LCD_TESTPAT_EN
    input  logic        tpat_sel,
`endif
    input  logic [23:0] pix_data,
    input  logic        pix_sof,
    input  logic        pix_valid,
    output logic        pix_ready,
    output logic        lcdclk,
    output logic [23:0] rgb,
    output logic        den,
    output logic        hsd,
    output logic        vsd,
    output logic        stbyb,
    output logic        frame_start,
    output logic        uf_sticky,
    output logic [15:0] uf_count
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW = $clog2(H_TOTAL + 1);
    localparam int VW = $clog2(V_TOTAL + 1);
    localparam int DW = $clog2(CLK_DIV);

    localparam logic [DW-1:0] DIV_LOAD = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2);
    localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_BEG   = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_BEG   = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);

    typedef enum logic {SEEK, LOCK} state_t;

    state_t        state, state_nxt;
    logic [DW-1:0] div_cnt;
    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic          tick, active, first, h_sync, v_sync;
    logic          tp_on, ready_c, uf_evt, fs_evt, sof_pix;
    logic [23:0]   rgb_nxt, bar_rgb;

    assign tick    = (div_cnt == '0);
    assign active  = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    assign first   = (h_cnt == '0) && (v_cnt == '0);
    assign h_sync  = (h_cnt >= HS_BEG) && (h_cnt < HS_END);
    assign v_sync  = (v_cnt >= VS_BEG) && (v_cnt < VS_END);
    assign sof_pix = pix_valid && pix_sof;

`ifdef LCD_TESTPAT_EN
    logic [2:0] bar_idx, bar_col;
    assign bar_idx = 3'((32'(h_cnt) * 32'd8) / 32'(H_ACTIVE));
    assign bar_col = 3'd7 - bar_idx;
    assign bar_rgb = {{8{bar_col[2]}}, {8{bar_col[1]}}, {8{bar_col[0]}}};
    assign tp_on   = tpat_sel;
`else
    assign bar_rgb = '0;
    assign tp_on   = 1'b0;
`endif

    // stbyb is low for the first clk after reset, which also keeps pix_ready low there
    assign pix_ready = ready_c && stbyb;

    always_comb begin
        state_nxt = state;
        ready_c   = 1'b0;
        uf_evt    = 1'b0;
        fs_evt    = 1'b0;
        rgb_nxt   = '0;
        if (tp_on) begin
            state_nxt = SEEK;
            if (active) rgb_nxt = bar_rgb;
        end else begin
            case (state)
                SEEK: begin
                    ready_c = !sof_pix || (tick && first);
                    if (tick && active) begin
                        rgb_nxt = UF_COLOR;
                        if (first && sof_pix) begin
                            state_nxt = LOCK;
                            rgb_nxt   = pix_data;
                            fs_evt    = 1'b1;
                        end
                    end
                end
                LOCK: begin
                    if (tick && active) begin
                        rgb_nxt = UF_COLOR;
                        if (!pix_valid) begin
                            ready_c = 1'b1;
                            uf_evt  = 1'b1;
                        end else if (pix_sof != first) begin
                            state_nxt = SEEK;
                            uf_evt    = 1'b1;
                        end else begin
                            ready_c = 1'b1;
                            rgb_nxt = pix_data;
                            fs_evt  = first;
                        end
                    end
                end
                default: state_nxt = SEEK;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= SEEK;
            div_cnt     <= DIV_LOAD;
            h_cnt       <= '0;
            v_cnt       <= '0;
            lcdclk      <= 1'b0;
            rgb         <= '0;
            den         <= 1'b0;
            hsd         <= 1'b1;
            vsd         <= 1'b1;
            stbyb       <= 1'b0;
            frame_start <= 1'b0;
            uf_sticky   <= 1'b0;
            uf_count    <= '0;
        end else begin
            stbyb       <= 1'b1;
            frame_start <= 1'b0;
            state       <= state_nxt;
            if (tick) begin
                div_cnt     <= DIV_LOAD;
                lcdclk      <= 1'b0;
                h_cnt       <= (h_cnt == H_LAST) ? '0 : h_cnt + HW'(1);
                if (h_cnt == H_LAST)
                    v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + VW'(1);
                rgb         <= rgb_nxt;
                den         <= active;
                hsd         <= !h_sync;
                vsd         <= !v_sync;
                frame_start <= fs_evt;
                if (uf_evt) begin
                    uf_sticky <= 1'b1;
                    if (uf_count != 16'hFFFF) uf_count <= uf_count + 16'd1;
                end
            end else begin
                div_cnt <= div_cnt - DW'(1);
                if (div_cnt == DIV_HALF) lcdclk <= 1'b1;
            end
        end
    end
endmodule
